// File: rtl/hdmi_link_pkg.sv
// Shared types and constants for the HDMI link bring-up sequencer.
// Holds the fixed 3-bit state encodings, default timing constants and counter widths.
package hdmi_link_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Fixed encodings, visible on the debug state port
    localparam state_t ST_RESET     = 3'd0;
    localparam state_t ST_WAIT_LOCK = 3'd1;
    localparam state_t ST_TX_RESET  = 3'd2;
    localparam state_t ST_SETTLE    = 3'd3;
    localparam state_t ST_ACTIVE    = 3'd4;
    localparam state_t ST_BLANK     = 3'd5;

    localparam int unsigned LOCK_STABLE_CYC_DEF = 1024;
    localparam int unsigned TX_RST_CYC_DEF      = 16;
    localparam int unsigned SETTLE_FRAMES_DEF   = 2;

    localparam int unsigned LOCK_CNT_W = 16;
    localparam int unsigned RST_CNT_W  = 8;
    localparam int unsigned FRM_CNT_W  = 4;
    localparam int unsigned LOSS_CNT_W = 8;

    // States in which a dropped PLL lock counts as a lock-loss event
    function automatic logic lock_guarded(input state_t s);
        return (s == ST_TX_RESET) || (s == ST_SETTLE) ||
               (s == ST_ACTIVE)   || (s == ST_BLANK);
    endfunction

    // States in which transmitter and timing generator are out of reset
    function automatic logic path_released(input state_t s);
        return (s == ST_SETTLE) || (s == ST_ACTIVE) || (s == ST_BLANK);
    endfunction

endpackage

// File: rtl/hdmi_link_ctrl_if.sv
// Signal bundle between the HDMI link sequencer and its PLL / pixel-domain neighbours.
// master: the sequencer side; slave: the surrounding PLL, timing and transmitter side.
interface hdmi_link_ctrl_if;

    logic                                  pll_locked;
    logic                                  video_vs;
    logic                                  enable;
    logic                                  tx_rst_n;
    logic                                  timing_rst_n;
    logic                                  video_en;
    logic                                  link_up;
    hdmi_link_pkg::state_t                 state;
    logic [hdmi_link_pkg::LOSS_CNT_W-1:0]  lock_loss_cnt;

    modport master (
        input  pll_locked,
        input  video_vs,
        input  enable,
        output tx_rst_n,
        output timing_rst_n,
        output video_en,
        output link_up,
        output state,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output video_vs,
        output enable,
        input  tx_rst_n,
        input  timing_rst_n,
        input  video_en,
        input  link_up,
        input  state,
        input  lock_loss_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_link_ctrl.sv
// HDMI colour-bar output bring-up sequencer: qualifies PLL lock, releases resets in order, frame-aligns video enable.
// Define HDMI_LINK_CTRL_STATS_EN to implement the saturating lock-loss counter; otherwise lock_loss_cnt reads 0.
module hdmi_link_ctrl
    import hdmi_link_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
    parameter int unsigned TX_RST_CYC      = TX_RST_CYC_DEF,
    parameter int unsigned SETTLE_FRAMES   = SETTLE_FRAMES_DEF,
    parameter bit          VS_POL          = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    hdmi_link_ctrl_if.master link
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RST_CNT_W-1:0]  RST_LAST  = RST_CNT_W'(TX_RST_CYC - 1);
    localparam logic [FRM_CNT_W-1:0]  FRM_LAST  = FRM_CNT_W'(SETTLE_FRAMES - 1);

    logic lock_s;
    logic vs_s;
    logic vs_d;
    logic vs_rise;

    state_t                state_q;
    state_t                state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q;
    logic [LOCK_CNT_W-1:0] lock_cnt_d;
    logic [RST_CNT_W-1:0]  rst_cnt_q;
    logic [RST_CNT_W-1:0]  rst_cnt_d;
    logic [FRM_CNT_W-1:0]  frm_cnt_q;
    logic [FRM_CNT_W-1:0]  frm_cnt_d;
    logic                  loss_evt;

    logic tx_rst_n_q;
    logic timing_rst_n_q;
    logic video_en_q;
    logic link_up_q;

    sync_2ff u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (link.pll_locked),
        .q   (lock_s)
    );

    sync_2ff u_vs_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (link.video_vs),
        .q   (vs_s)
    );

    // Third vsync flop: edge detect from inactive to active level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= vs_s;
        end
    end

    assign vs_rise = (vs_s == VS_POL) && (vs_d != VS_POL);

    // State and counter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_RESET;
            lock_cnt_q <= '0;
            rst_cnt_q  <= '0;
            frm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    // Next-state and counter logic; lock loss overrides every other transition
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        loss_evt   = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_TX_RESET;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            ST_TX_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_SETTLE;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (vs_rise) begin
                    if (frm_cnt_q == FRM_LAST) begin
                        state_d   = link.enable ? ST_ACTIVE : ST_BLANK;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (vs_rise && !link.enable) begin
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (vs_rise && link.enable) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (!lock_s && lock_guarded(state_q)) begin
            state_d    = ST_WAIT_LOCK;
            lock_cnt_d = '0;
            rst_cnt_d  = '0;
            frm_cnt_d  = '0;
            loss_evt   = 1'b1;
        end
    end

    // Outputs follow the state being entered so they line up with the state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_rst_n_q     <= 1'b0;
            timing_rst_n_q <= 1'b0;
            video_en_q     <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            tx_rst_n_q     <= path_released(state_d);
            timing_rst_n_q <= path_released(state_d);
            video_en_q     <= (state_d == ST_ACTIVE);
            link_up_q      <= (state_d == ST_ACTIVE) || (state_d == ST_BLANK);
        end
    end

    assign link.tx_rst_n     = tx_rst_n_q;
    assign link.timing_rst_n = timing_rst_n_q;
    assign link.video_en     = video_en_q;
    assign link.link_up      = link_up_q;
    assign link.state        = state_q;

`ifdef HDMI_LINK_CTRL_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    // Saturating lock-loss event counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            loss_cnt_q <= '0;
        end else if (loss_evt && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign link.lock_loss_cnt = loss_cnt_q;
`else
    logic unused_loss_evt;

    assign unused_loss_evt    = loss_evt;
    assign link.lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Self-checking bench for hdmi_link_ctrl: randomized lock/enable stimulus against a cycle-level reference model.
`timescale 1ns/1ps
module tb_hdmi_link_ctrl;
    import hdmi_link_pkg::*;

    localparam int unsigned LSC = 8;
    localparam int unsigned TXC = 4;
    localparam int unsigned SF  = 2;
    localparam bit          VSP = 1'b1;
    localparam int FRAME_LEN = 30;
    localparam int VS_WIDTH  = 3;
`ifdef HDMI_LINK_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst;

    hdmi_link_ctrl_if lif ();

    hdmi_link_ctrl #(
        .LOCK_STABLE_CYC (LSC),
        .TX_RST_CYC      (TXC),
        .SETTLE_FRAMES   (SF),
        .VS_POL          (VSP)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .link    (lif)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_pos = 0;

    // Reference model: state number, run lengths and event counts
    int   m_state;
    int   m_stable;
    int   m_txc;
    int   m_frames;
    int   m_losses;
    logic lk_h [2];
    logic vs_h [3];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_stable = 0;
        m_txc    = 0;
        m_frames = 0;
        m_losses = 0;
        for (int i = 0; i < 2; i++) lk_h[i] = 1'b0;
        for (int i = 0; i < 3; i++) vs_h[i] = 1'b0;
    endtask

    // One clock edge of behaviour, using input values as they appear after synchronisation
    task automatic model_step();
        logic lk, vsr, en;
        lk  = lk_h[1];
        vsr = (vs_h[1] == VSP) && (vs_h[2] != VSP);
        en  = lif.enable;
        lk_h[1] = lk_h[0];
        lk_h[0] = lif.pll_locked;
        vs_h[2] = vs_h[1];
        vs_h[1] = vs_h[0];
        vs_h[0] = lif.video_vs;

        if (m_state == 0) begin
            m_state  = 1;
            m_stable = 0;
        end else if (m_state == 1) begin
            m_stable = lk ? m_stable + 1 : 0;
            if (m_stable == LSC) begin
                m_state = 2;
                m_txc   = 0;
            end
        end else if (!lk) begin
            m_state  = 1;
            m_stable = 0;
            m_losses++;
        end else if (m_state == 2) begin
            m_txc++;
            if (m_txc == TXC) begin
                m_state  = 3;
                m_frames = 0;
            end
        end else if (m_state == 3) begin
            if (vsr) m_frames++;
            if (m_frames == SF) m_state = en ? 4 : 5;
        end else if (m_state == 4) begin
            if (vsr && !en) m_state = 5;
        end else if (m_state == 5) begin
            if (vsr && en) m_state = 4;
        end
    endtask

    function automatic int exp_loss();
        if (!STATS) return 0;
        return (m_losses > 255) ? 255 : m_losses;
    endfunction

    task automatic check_outputs();
        chk("state",         16'(lif.state),         16'(m_state));
        chk("tx_rst_n",      16'(lif.tx_rst_n),      16'(m_state >= 3));
        chk("timing_rst_n",  16'(lif.timing_rst_n),  16'(m_state >= 3));
        chk("video_en",      16'(lif.video_en),      16'(m_state == 4));
        chk("link_up",       16'(lif.link_up),       16'(m_state >= 4));
        chk("lock_loss_cnt", 16'(lif.lock_loss_cnt), 16'(exp_loss()));
    endtask

    // Advance one cycle: model at the edge, compare 2 ns later, then move the vsync generator
    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst) model_reset();
        else model_step();
        #2;
        cyc++;
        if (!sys_rst) check_outputs();
        frame_pos = (frame_pos + 1) % FRAME_LEN;
        lif.video_vs = (frame_pos < VS_WIDTH) ? VSP : ~VSP;
    endtask

    task automatic wait_state(input string tag, input state_t target, input int budget);
        int n;
        n = 0;
        while (lif.state != target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 16'(lif.state), 16'(target));
    endtask

    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        while (frame_pos != pos && n <= FRAME_LEN) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int loss_before;
        logic dropped;

        sys_rst = 1'b1;
        lif.pll_locked = 1'b0;
        lif.video_vs   = ~VSP;
        lif.enable     = 1'b0;
        model_reset();
        #1;
        chk("rst_state",    16'(lif.state),         16'(0));
        chk("rst_tx",       16'(lif.tx_rst_n),      16'(0));
        chk("rst_timing",   16'(lif.timing_rst_n),  16'(0));
        chk("rst_video_en", 16'(lif.video_en),      16'(0));
        chk("rst_link_up",  16'(lif.link_up),       16'(0));
        chk("rst_loss",     16'(lif.lock_loss_cnt), 16'(0));
        repeat (3) tick();
        sys_rst = 1'b0;

        // Clean bring-up with enable held high
        lif.enable = 1'b1;
        while (cyc < 10) tick();
        lif.pll_locked = 1'b1;
        n = 0;
        while (!lif.tx_rst_n && n < 60) begin
            tick();
            n++;
        end
        chk("tx_rise_latency_in_13_15", 16'(n >= 13 && n <= 15), 16'(1));
        chk("timing_with_tx", 16'(lif.timing_rst_n), 16'(1));
        wait_state("bringup_active", ST_ACTIVE, 4 * FRAME_LEN);
        chk("bringup_link_up", 16'(lif.link_up), 16'(1));

        // Enable pulsed low between vsyncs must not disturb video
        wait_pos(8);
        dropped = 1'b0;
        lif.enable = 1'b0;
        repeat ($urandom_range(2, 10)) begin
            tick();
            if (!lif.video_en) dropped = 1'b1;
        end
        lif.enable = 1'b1;
        while (frame_pos != 26) begin
            tick();
            if (!lif.video_en) dropped = 1'b1;
        end
        chk("midframe_toggle_video", 16'(dropped), 16'(0));
        chk("midframe_toggle_state", 16'(lif.state), 16'(ST_ACTIVE));

        // Disable across a vsync, then re-enable: both changes land 3 cycles after vsync
        wait_pos(10);
        lif.enable = 1'b0;
        n = 0;
        while (lif.video_en && n < 2 * FRAME_LEN) begin
            tick();
            n++;
        end
        chk("disable_fall", 16'(lif.video_en), 16'(0));
        chk("disable_align", 16'(frame_pos), 16'(3));
        lif.enable = 1'b1;
        n = 0;
        while (!lif.video_en && n < 2 * FRAME_LEN) begin
            tick();
            n++;
        end
        chk("reenable_rise", 16'(lif.video_en), 16'(1));
        chk("reenable_align", 16'(frame_pos), 16'(3));

        // Lock loss while ACTIVE
        lif.pll_locked = 1'b0;
        repeat (3) tick();
        chk("loss_video_en", 16'(lif.video_en), 16'(0));
        chk("loss_tx", 16'(lif.tx_rst_n), 16'(0));
        chk("loss_timing", 16'(lif.timing_rst_n), 16'(0));
        chk("loss_state", 16'(lif.state), 16'(ST_WAIT_LOCK));
        chk("loss_count", 16'(lif.lock_loss_cnt), 16'(STATS ? 1 : 0));

        // One-cycle lock glitch during WAIT_LOCK restarts qualification
        repeat (4) tick();
        lif.pll_locked = 1'b1;
        repeat (7) tick();
        loss_before = int'(lif.lock_loss_cnt);
        lif.pll_locked = 1'b0;
        tick();
        lif.pll_locked = 1'b1;
        n = 0;
        while (lif.state != ST_TX_RESET && n < 40) begin
            tick();
            n++;
        end
        chk("glitch_relock_cycles", 16'(n), 16'(10));
        chk("glitch_no_loss", 16'(lif.lock_loss_cnt), 16'(loss_before));

        // Randomised run: enable toggles and lock drops of random length
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lif.enable = ~lif.enable;
            if ($urandom_range(0, 299) == 0) begin
                lif.pll_locked = 1'b0;
                repeat ($urandom_range(1, 20)) tick();
                lif.pll_locked = 1'b1;
            end
            tick();
        end

        // Drive enough lock-loss events to saturate the counter
        for (int i = 0; i < 300; i++) begin
            lif.pll_locked = 1'b1;
            n = 0;
            while (lif.state != ST_TX_RESET && n < 40) begin
                tick();
                n++;
            end
            lif.pll_locked = 1'b0;
            repeat (3) tick();
        end
        chk("loss_saturated", 16'(lif.lock_loss_cnt), 16'(STATS ? 255 : 0));

        // Asynchronous reset in the middle of operation
        lif.pll_locked = 1'b1;
        lif.enable     = 1'b1;
        wait_state("pre_reset_active", ST_ACTIVE, 6 * FRAME_LEN);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_state",    16'(lif.state),         16'(0));
        chk("async_rst_tx",       16'(lif.tx_rst_n),      16'(0));
        chk("async_rst_timing",   16'(lif.timing_rst_n),  16'(0));
        chk("async_rst_video_en", 16'(lif.video_en),      16'(0));
        chk("async_rst_link_up",  16'(lif.link_up),       16'(0));
        chk("async_rst_loss",     16'(lif.lock_loss_cnt), 16'(0));
        model_reset();
        repeat (2) tick();
        sys_rst = 1'b0;
        wait_state("post_reset_active", ST_ACTIVE, 6 * FRAME_LEN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
